btn_debouncer: RTL and testbench
================================

Name: btn_debouncer

Overview:
- Debounces one noisy, asynchronous push-button input into a clean level in the `clk` domain.
- Emits a single-cycle pulse when the debounced level leaves its idle (released) state, i.e. on a button press.
- Sits between board button pins and control logic such as mode/select FSMs.
- One instance per button.

Parameters:
- CLKIN_FREQ, 27000000, clock frequency in Hz (integer).
- DEBOUNCE_PERIOD, 10e-3, required stable time in seconds (real).
- IDLE_STATE, 1'b1, level of the input when the button is released (1 = active-low button).

Ports:
- clk  input  1  system clock at CLKIN_FREQ.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- noisyIn  input  1  raw button input; asynchronous and bouncy.
- debounceOut  output  1  registered debounced level.
- edgeDetectOut  output  1  registered one-clock press pulse.

Behaviour:
- One clock, `clk`. Reset is asynchronous and active-low: `reset` = 0 clears state immediately, without waiting for a clock edge.
- Derived constant N = ceil(CLKIN_FREQ*DEBOUNCE_PERIOD), clamped to a minimum of 1. Example: 27 MHz × 250 ns = 6.75, so N = 7.
- Counter width = $clog2(N+1); must not overflow.
- Synchronizer:
  - noisyIn passes through 2 flip-flops; the output is s.
  - Both flops reset to IDLE_STATE.
- Counter cnt, reset to 0. Evaluated every clock:
  - If s == debounceOut: cnt <= 0.
  - Else if cnt == N-1: debounceOut <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
- Consequences of the counter rule:
  - s must differ from debounceOut on N consecutive clocks before debounceOut changes.
  - Any sample equal to debounceOut restarts the count; no partial credit is retained.
- Latency from a clean input step to debounceOut change: 2 (synchronizer) + N clocks.
- edgeDetectOut:
  - High for exactly one clock, in the same cycle debounceOut first shows ~IDLE_STATE.
  - Low at all other times, including on release (debounceOut returning to IDLE_STATE).
- Reset values: debounceOut = IDLE_STATE, edgeDetectOut = 0, cnt = 0, synchronizer = IDLE_STATE.
- Boundary conditions:
  - Bounce shorter than N clocks: produces no output change and no pulse.
  - Reset asserted mid-count: the count is discarded and outputs return to reset values.
  - Input held at ~IDLE_STATE through reset release: after release, press is detected after 2+N clocks and the pulse fires.
  - Continuous hold: exactly one pulse per press; no auto-repeat.
- A no-op: noisyIn toggling while debounceOut already equals the new level only clears cnt.

Optional Feature:
- Macro: BTN_DEBOUNCER_RELEASE_EDGE_EN.
- Defined: edgeDetectOut also pulses for one clock when debounceOut returns to IDLE_STATE, so it pulses on both transitions.
- Not defined: press-only pulse, as specified in Behaviour.
- Port list is identical in both builds.

Test Plan:
- Settings for all scenarios: CLKIN_FREQ=27000000, DEBOUNCE_PERIOD=250e-9, IDLE_STATE=1, giving N=7 at a 37.04 ns clock period.
- Reset: hold `reset`=0 with noisyIn=1 for 100 ns -> debounceOut=1, edgeDetectOut=0; also assert reset asynchronously between clock edges -> outputs clear immediately.
- Glitch rejection: noisyIn alternates 0/1 every 60 ns for 4 segments -> debounceOut stays 1, edgeDetectOut never high.
- Press: noisyIn=0 held 300 ns after the glitches -> debounceOut falls 9 clocks after the last edge; edgeDetectOut high for exactly 1 clock, coincident with the fall.
- Release: noisyIn=1 held 1000 ns -> debounceOut returns to 1 after 9 clocks; edgeDetectOut stays 0 (or pulses once with BTN_DEBOUNCER_RELEASE_EDGE_EN).
- Repeat press: a second glitch burst followed by a 300 ns low -> exactly one more pulse; a low lasting exactly 6 clocks after synchronization -> no change.
- Mid-count reset: assert reset after 4 clocks of a stable low -> after release, debounceOut changes only after a full 2+7 clocks.

Source files
------------

// File: rtl/btn_debouncer.sv
// Debounces one asynchronous push-button into a clean clk-domain level and emits a
// one-clock pulse on press (also on release when BTN_DEBOUNCER_RELEASE_EDGE_EN is defined).
// Latency 2+N clocks from a clean input step; no backpressure, one instance per button.
module btn_debouncer #(
    parameter int   CLKIN_FREQ      = 27000000,
    parameter real  DEBOUNCE_PERIOD = 10e-3,
    parameter logic IDLE_STATE      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic noisyIn,
    output logic debounceOut,
    output logic edgeDetectOut
);

    // N = ceil(CLKIN_FREQ * DEBOUNCE_PERIOD), never below 1
    localparam real PROD    = real'(CLKIN_FREQ) * DEBOUNCE_PERIOD;
    localparam int  N_TRUNC = $rtoi(PROD);
    localparam int  N_CEIL  = (real'(N_TRUNC) < PROD) ? N_TRUNC + 1 : N_TRUNC;
    localparam int  N       = (N_CEIL < 1) ? 1 : N_CEIL;
    localparam int  CW      = $clog2(N + 1);
    localparam logic [CW-1:0] TERM = CW'(N - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          edge_q, edge_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= IDLE_STATE;
            sync2_q <= IDLE_STATE;
            deb_q   <= IDLE_STATE;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= noisyIn;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        deb_d  = deb_q;
        edge_d = 1'b0;
        cnt_d  = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            deb_d = sync2_q;
            cnt_d = '0;
`ifdef BTN_DEBOUNCER_RELEASE_EDGE_EN
            edge_d = 1'b1;
`else
            edge_d = (sync2_q != IDLE_STATE);
`endif
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign debounceOut   = deb_q;
    assign edgeDetectOut = edge_q;

endmodule

// File: tb/tb_btn_debouncer.sv
`timescale 1ns/1ps
module tb_btn_debouncer;

`ifdef BTN_DEBOUNCER_RELEASE_EDGE_EN
    localparam logic REL = 1'b1;
`else
    localparam logic REL = 1'b0;
`endif
    localparam int R = REL ? 1 : 0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic noisyIn = 1'b1;
    logic debounceOut;
    logic edgeDetectOut;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    btn_debouncer #(
        .CLKIN_FREQ     (27000000),
        .DEBOUNCE_PERIOD(250e-9),
        .IDLE_STATE     (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .noisyIn      (noisyIn),
        .debounceOut  (debounceOut),
        .edgeDetectOut(edgeDetectOut)
    );

    always #18.52 clk = ~clk;

    always @(negedge clk) if (edgeDetectOut === 1'b1) pulses++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset held with button released
        #100;
        check("rst_deb", debounceOut, 1);
        check("rst_edge", edgeDetectOut, 0);
        @(negedge clk) reset = 1'b1;
        tick(3);
        check("idle_deb", debounceOut, 1);

        // glitch burst: lows of 3 clocks never reach N
        for (int i = 0; i < 4; i++) begin
            noisyIn = 1'b0; tick(3);
            noisyIn = 1'b1; tick(1);
        end
        check("glitch_deb", debounceOut, 1);
        check("glitch_pulses", pulses, 0);

        // press
        noisyIn = 1'b0;
        tick(8);
        check("press_pre_deb", debounceOut, 1);
        check("press_pre_edge", edgeDetectOut, 0);
        tick(1);
        check("press_deb", debounceOut, 0);
        check("press_edge", edgeDetectOut, 1);
        tick(1);
        check("press_post_edge", edgeDetectOut, 0);
        tick(20);
        check("hold_deb", debounceOut, 0);
        check("hold_pulses", pulses, 1);

        // release
        noisyIn = 1'b1;
        tick(8);
        check("rel_pre_deb", debounceOut, 0);
        tick(1);
        check("rel_deb", debounceOut, 1);
        check("rel_edge", edgeDetectOut, REL);
        tick(5);
        check("rel_pulses", pulses, 1 + R);

        // low of exactly 6 clocks is rejected
        noisyIn = 1'b0; tick(6);
        noisyIn = 1'b1; tick(12);
        check("six_deb", debounceOut, 1);
        check("six_pulses", pulses, 1 + R);

        // low of exactly 7 clocks is accepted
        noisyIn = 1'b0; tick(7);
        noisyIn = 1'b1; tick(2);
        check("seven_deb", debounceOut, 0);
        check("seven_edge", edgeDetectOut, 1);
        tick(6);
        check("seven_hold_deb", debounceOut, 0);
        tick(1);
        check("seven_rel_deb", debounceOut, 1);
        tick(3);
        check("seven_pulses", pulses, 2 + 2 * R);

        // second burst then press
        for (int i = 0; i < 3; i++) begin
            noisyIn = 1'b0; tick(5);
            noisyIn = 1'b1; tick(2);
        end
        check("burst2_deb", debounceOut, 1);
        noisyIn = 1'b0;
        tick(9);
        check("press2_deb", debounceOut, 0);
        check("press2_edge", edgeDetectOut, 1);
        tick(4);
        check("press2_pulses", pulses, 3 + 2 * R);

        // asynchronous reset between edges clears outputs at once
        @(posedge clk);
        #5 reset = 1'b0;
        #1;
        check("async_deb", debounceOut, 1);
        check("async_edge", edgeDetectOut, 0);
        noisyIn = 1'b1;
        @(negedge clk) reset = 1'b1;
        tick(3);

        // reset mid-count with input held low through release
        noisyIn = 1'b0;
        tick(4);
        #5 reset = 1'b0;
        #1;
        check("mid_rst_deb", debounceOut, 1);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        tick(8);
        check("mid_pre_deb", debounceOut, 1);
        check("mid_pre_edge", edgeDetectOut, 0);
        tick(1);
        check("mid_deb", debounceOut, 0);
        check("mid_edge", edgeDetectOut, 1);
        tick(1);
        check("mid_post_edge", edgeDetectOut, 0);
        check("mid_pulses", pulses, 4 + 2 * R);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
